hedios_reg_write_arbiter: RTL and testbench
===========================================

# hedios_reg_write_arbiter

Arbitrates two write requesters, the HEDIOS side and the user side, onto a bank of NREGS registers of DEPTH bits, so the register bank never sees two simultaneous writes. Each requester has a valid/ready handshake. Grants follow round-robin with bounded bursts. Every accepted write is presented to the bank as a registered, one-hot write strobe with its data. The block sits between the two write sources and the register bank, and replaces race detection with lossless serialization.

## Interface
- DEPTH, 8, data width of each register
- NREGS, 4, number of registers in the bank (2..256)
- ADDR_W, 2, address width; ceil(log2(NREGS)), minimum 1
- MAX_BURST, 4, maximum consecutive beats an owner keeps while the other side waits (1..15)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- h_valid  in  1  HEDIOS write request
- h_ready  out  1  HEDIOS request accepted this cycle
- h_addr  in  ADDR_W  HEDIOS target register
- h_data  in  DEPTH  HEDIOS write data
- u_valid  in  1  user write request
- u_ready  out  1  user request accepted this cycle
- u_addr  in  ADDR_W  user target register
- u_data  in  DEPTH  user write data
- wr_en  out  NREGS  one-hot per-register write strobe to the bank
- wr_data  out  DEPTH  write data broadcast to the bank
- conflict_cnt  out  8  saturating count of cycles with both valids high
- addr_err  out  1  sticky; an accepted beat had addr >= NREGS

## Operation
- Beat: valid && ready on one side. At most one beat per cycle; h_ready && u_ready is never 1.
- Requesters must hold valid, addr and data stable while valid && !ready.
- The FSM has three states: IDLE, OWN_H and OWN_U. It also holds rr_last (the last granted side) and beat_cnt (4 bits).
- Grant decision is combinational from state, valids, rr_last and beat_cnt:
  - IDLE, or the owner's valid is low: if only one valid, grant that side. If both are valid, grant the side != rr_last.
  - OWN_X with X valid: if the other side is not valid, keep X. If the other side is valid and beat_cnt < MAX_BURST, keep X. Otherwise grant the other side.
  - Neither valid: no grant; next state is IDLE.
- On a granted beat:
  - state becomes OWN_side and rr_last becomes side.
  - beat_cnt becomes 1 on an owner change or from IDLE. Otherwise beat_cnt increments, saturating at 15.
- A write is accepted if addr < NREGS:
  - Next cycle: wr_en = one-hot(addr) and wr_data = the beat's data.
  - Otherwise the beat completes the handshake but wr_en stays 0, and addr_err sets, sticky until rst.
- conflict_cnt increments every cycle with h_valid && u_valid, saturating at 255.
- Same address written by both sides back-to-back: both writes occur in grant order; the bank holds the later one.

## Timing
- h_ready and u_ready are combinational from the current inputs and registered state; no wait cycle is needed from IDLE.
- Write latency: a beat in cycle N produces wr_en/wr_data in cycle N+1, for one cycle only. With continuous beats, wr_en is asserted every cycle.
- wr_data holds its last value when wr_en = 0.
- Reset values:
  - state = IDLE, rr_last = U, so HEDIOS wins the first tie.
  - beat_cnt = 0, wr_en = 0, wr_data = 0, conflict_cnt = 0, addr_err = 0.
- h_ready and u_ready are forced to 0 in any cycle where rst = 1.
- Reset mid-burst:
  - The beat in the reset cycle is not accepted.
  - The write staged from the cycle before reset is cancelled (wr_en = 0 the cycle after rst).
  - Arbitration restarts from IDLE.
- MAX_BURST = 1 yields strict alternation under continuous contention.

## Test plan
- Single write: rst, then h_valid=1, h_addr=2, h_data=0xA5 for one cycle. Required: h_ready=1 that cycle; next cycle wr_en=4'b0100, wr_data=0xA5; then wr_en=0.
- First tie: both valid from reset, h_data=0x11, u_data=0x22, both addr 1. Required: H granted first; wr_data sequence 0x11 then 0x22 on reg 1; conflict_cnt=1.
- Burst limit: MAX_BURST=4, H valid continuously, U valid from cycle 2. Required: H gets 4 consecutive beats, then U granted; no cycle with both readys high.
- Out-of-range address: NREGS=3, u_addr=3. Required: u_ready=1, wr_en stays 0, addr_err=1 and stays 1 through later valid writes until rst.
- Reset mid-burst: assert rst for one cycle during an OWN_U burst. Required: no ready that cycle; wr_en=0 the next cycle; all outputs at reset values; the next tie is granted to H.
- Saturation: hold both valids for 300 cycles. Required: conflict_cnt=255 and stays there; wr_en one-hot every cycle.

Source files
------------

// File: rtl/hedios_reg_write_arbiter.sv
// hedios_reg_write_arbiter
// Serializes writes from the HEDIOS side and the user side onto one register
// bank. Round-robin arbitration with a bounded burst length means a busy
// owner cannot starve the other side. Every accepted beat reaches the bank
// one cycle later as a registered one-hot strobe plus data.
module hedios_reg_write_arbiter #(
  parameter int DEPTH     = 8,
  parameter int NREGS     = 4,
  parameter int ADDR_W    = 2,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              h_valid,
  output logic              h_ready,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DEPTH-1:0]  h_data,
  input  logic              u_valid,
  output logic              u_ready,
  input  logic [ADDR_W-1:0] u_addr,
  input  logic [DEPTH-1:0]  u_data,
  output logic [NREGS-1:0]  wr_en,
  output logic [DEPTH-1:0]  wr_data,
  output logic [7:0]        conflict_cnt,
  output logic              addr_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_H = 2'd1,
    OWN_U = 2'd2
  } state_t;

  // rr_last encoding: which side was granted most recently
  localparam logic SIDE_H = 1'b0;
  localparam logic SIDE_U = 1'b1;

  localparam logic [3:0]      MAX_BURST_C = 4'(MAX_BURST);
  localparam logic [ADDR_W:0] NREGS_C     = (ADDR_W + 1)'(NREGS);

  state_t            state_q;
  logic              rr_last_q;
  logic [3:0]        beat_cnt_q;
  logic [NREGS-1:0]  wr_en_q;
  logic [DEPTH-1:0]  wr_data_q;
  logic [7:0]        conflict_cnt_q;
  logic              addr_err_q;

  logic              grant_h;
  logic              grant_u;
  logic              beat;
  logic              burst_open;
  logic              same_owner;
  logic              addr_ok;
  logic [ADDR_W-1:0] sel_addr;
  logic [DEPTH-1:0]  sel_data;
  logic [3:0]        beat_cnt_d;
  logic [NREGS-1:0]  wr_en_d;

  assign burst_open = (beat_cnt_q < MAX_BURST_C);

  // Grant decision: the owner keeps the bank while it has a short enough
  // run or nobody else is waiting; otherwise the side that did not win last
  // time gets it. Reset forces both readys low so no beat completes.
  always_comb begin
    grant_h = 1'b0;
    grant_u = 1'b0;
    if (!rst) begin
      if (state_q == OWN_H && h_valid) begin
        if (!u_valid || burst_open) grant_h = 1'b1;
        else                        grant_u = 1'b1;
      end else if (state_q == OWN_U && u_valid) begin
        if (!h_valid || burst_open) grant_u = 1'b1;
        else                        grant_h = 1'b1;
      end else if (h_valid && u_valid) begin
        if (rr_last_q == SIDE_U) grant_h = 1'b1;
        else                     grant_u = 1'b1;
      end else begin
        grant_h = h_valid;
        grant_u = u_valid;
      end
    end
  end

  // Mux the winning beat and work out what the bank and counters should see
  always_comb begin
    beat       = grant_h | grant_u;
    sel_addr   = grant_h ? h_addr : u_addr;
    sel_data   = grant_h ? h_data : u_data;
    addr_ok    = ({1'b0, sel_addr} < NREGS_C);
    same_owner = (grant_h && state_q == OWN_H) || (grant_u && state_q == OWN_U);
    if (!same_owner)               beat_cnt_d = 4'd1;
    else if (beat_cnt_q != 4'hF)   beat_cnt_d = beat_cnt_q + 4'd1;
    else                           beat_cnt_d = beat_cnt_q;
    wr_en_d = NREGS'(1) << sel_addr;
  end

  // Arbitration FSM plus registered bank strobe, data and status counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      rr_last_q      <= SIDE_U;
      beat_cnt_q     <= 4'd0;
      wr_en_q        <= '0;
      wr_data_q      <= '0;
      conflict_cnt_q <= 8'd0;
      addr_err_q     <= 1'b0;
    end else begin
      if (h_valid && u_valid && conflict_cnt_q != 8'hFF)
        conflict_cnt_q <= conflict_cnt_q + 8'd1;

      wr_en_q <= '0;
      if (beat) begin
        state_q    <= grant_h ? OWN_H : OWN_U;
        rr_last_q  <= grant_h ? SIDE_H : SIDE_U;
        beat_cnt_q <= beat_cnt_d;
        if (addr_ok) begin
          wr_en_q   <= wr_en_d;
          wr_data_q <= sel_data;
        end else begin
          addr_err_q <= 1'b1;
        end
      end else begin
        state_q <= IDLE;
      end
    end
  end

  assign h_ready      = grant_h;
  assign u_ready      = grant_u;
  assign wr_en        = wr_en_q;
  assign wr_data      = wr_data_q;
  assign conflict_cnt = conflict_cnt_q;
  assign addr_err     = addr_err_q;

endmodule

// File: tb/tb_hedios_reg_write_arbiter.sv
// Testbench for hedios_reg_write_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of round-robin arbitration with bounded runs.
module tb_hedios_reg_write_arbiter;

  localparam int DEPTH     = 8;
  localparam int NREGS     = 3;
  localparam int ADDR_W    = 2;
  localparam int MAX_BURST = 4;

  logic              clk;
  logic              rst;
  logic              h_valid;
  logic              h_ready;
  logic [ADDR_W-1:0] h_addr;
  logic [DEPTH-1:0]  h_data;
  logic              u_valid;
  logic              u_ready;
  logic [ADDR_W-1:0] u_addr;
  logic [DEPTH-1:0]  u_data;
  logic [NREGS-1:0]  wr_en;
  logic [DEPTH-1:0]  wr_data;
  logic [7:0]        conflict_cnt;
  logic              addr_err;

  int checkCount = 0;
  int errCount   = 0;

  hedios_reg_write_arbiter #(
    .DEPTH(DEPTH), .NREGS(NREGS), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .h_valid(h_valid), .h_ready(h_ready), .h_addr(h_addr), .h_data(h_data),
    .u_valid(u_valid), .u_ready(u_ready), .u_addr(u_addr), .u_data(u_data),
    .wr_en(wr_en), .wr_data(wr_data),
    .conflict_cnt(conflict_cnt), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Side codes: 0 none, 1 HEDIOS, 2 user
  int  mLast;
  bit  mActive;
  int  mStreak;
  int  mWrEn;
  int  mWrData;
  int  mConf;
  bit  mErr;
  bit  started = 1'b0;

  function automatic int pickWinner(bit hv, bit uv);
    if (hv && !uv) return 1;
    if (uv && !hv) return 2;
    if (!hv && !uv) return 0;
    if (mActive && mStreak < MAX_BURST) return mLast;
    return (mLast == 1) ? 2 : 1;
  endfunction

  // Compare DUT against the model on every falling edge, then advance the
  // model with the inputs that the next rising edge will sample
  always @(negedge clk) begin
    int w;
    int a;
    int d;
    w = rst ? 0 : pickWinner(h_valid, u_valid);
    if (started) begin
      checkOutput("h_ready", h_ready, w == 1);
      checkOutput("u_ready", u_ready, w == 2);
      checkOutput("wr_en", wr_en, mWrEn);
      checkOutput("wr_data", wr_data, mWrData);
      checkOutput("conflict_cnt", conflict_cnt, mConf);
      checkOutput("addr_err", addr_err, mErr);
    end
    if (rst) begin
      mLast = 2; mActive = 0; mStreak = 0;
      mWrEn = 0; mWrData = 0; mConf = 0; mErr = 0;
      started = 1'b1;
    end else begin
      if (h_valid && u_valid && mConf < 255) mConf++;
      if (w != 0) begin
        a = (w == 1) ? int'(h_addr) : int'(u_addr);
        d = (w == 1) ? int'(h_data) : int'(u_data);
        if (a < NREGS) begin
          mWrEn = 1 << a;
          mWrData = d;
        end else begin
          mWrEn = 0;
          mErr = 1;
        end
        mStreak = (mActive && mLast == w) ? mStreak + 1 : 1;
        mLast = w;
        mActive = 1;
      end else begin
        mWrEn = 0;
        mActive = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit hv, input int ha, input int hd,
                               input bit uv, input int ua, input int ud);
    h_valid = hv; h_addr = ADDR_W'(ha); h_data = DEPTH'(hd);
    u_valid = uv; u_addr = ADDR_W'(ua); u_data = DEPTH'(ud);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Random traffic honouring the hold-while-stalled rule, with optional resets
  task automatic runRandom(input int cycles, input bit bothAlways,
                           input bit withReset);
    bit hA;
    bit uA;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      hA = h_ready;
      uA = u_ready;
      if (bothAlways && i >= 1)
        checkOutput("sat_onehot", 32'($onehot(wr_en)), 1);
      tick();
      if (withReset) begin
        if (rst) rst = 1'b0;
        else if ($urandom_range(199) == 0) rst = 1'b1;
      end
      if (!h_valid || hA) begin
        h_valid = bothAlways ? 1'b1 : ($urandom_range(9) < 6);
        h_addr  = bothAlways ? ADDR_W'($urandom_range(NREGS - 1))
                             : ADDR_W'($urandom_range(3));
        h_data  = DEPTH'($urandom);
      end
      if (!u_valid || uA) begin
        u_valid = bothAlways ? 1'b1 : ($urandom_range(9) < 6);
        u_addr  = bothAlways ? ADDR_W'($urandom_range(NREGS - 1))
                             : ADDR_W'($urandom_range(3));
        u_data  = DEPTH'($urandom);
      end
    end
  endtask

  // ---------------- directed and random scenarios ----------------
  initial begin
    bit expH [6] = '{1, 1, 1, 1, 0, 0};
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyReset();

    @(negedge clk);
    checkOutput("reset_wr_en", wr_en, 0);
    checkOutput("reset_wr_data", wr_data, 0);
    checkOutput("reset_conflict", conflict_cnt, 0);
    checkOutput("reset_addr_err", addr_err, 0);

    // Single write
    tick();
    applyStimulus(1, 2, 'hA5, 0, 0, 0);
    @(negedge clk);
    checkOutput("single_h_ready", h_ready, 1);
    checkOutput("single_u_ready", u_ready, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("single_wr_en", wr_en, 3'b100);
    checkOutput("single_wr_data", wr_data, 'hA5);
    tick();
    @(negedge clk);
    checkOutput("single_wr_en_off", wr_en, 0);
    checkOutput("single_wr_data_hold", wr_data, 'hA5);

    // First tie after reset goes to HEDIOS
    tick();
    applyReset();
    applyStimulus(1, 1, 'h11, 1, 1, 'h22);
    @(negedge clk);
    checkOutput("tie_h_ready", h_ready, 1);
    checkOutput("tie_u_ready", u_ready, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 1, 'h22);
    @(negedge clk);
    checkOutput("tie_u_ready2", u_ready, 1);
    checkOutput("tie_wr_en1", wr_en, 3'b010);
    checkOutput("tie_wr_data1", wr_data, 'h11);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("tie_wr_en2", wr_en, 3'b010);
    checkOutput("tie_wr_data2", wr_data, 'h22);
    checkOutput("tie_conflict", conflict_cnt, 1);

    // Burst limit: HEDIOS continuous, user joins at cycle 2
    tick();
    applyReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 'h50, i >= 2, 1, 'h60);
      @(negedge clk);
      checkOutput($sformatf("burst_h_ready_%0d", i), h_ready, expH[i]);
      checkOutput($sformatf("burst_u_ready_%0d", i), u_ready, !expH[i]);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Out-of-range address
    applyReset();
    applyStimulus(0, 0, 0, 1, 3, 'h77);
    @(negedge clk);
    checkOutput("oor_u_ready", u_ready, 1);
    tick();
    applyStimulus(1, 0, 'h33, 0, 0, 0);
    @(negedge clk);
    checkOutput("oor_wr_en", wr_en, 0);
    checkOutput("oor_addr_err", addr_err, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("oor_next_wr_en", wr_en, 3'b001);
    checkOutput("oor_next_wr_data", wr_data, 'h33);
    checkOutput("oor_err_sticky", addr_err, 1);

    // Reset in the middle of a user burst
    tick();
    applyReset();
    applyStimulus(0, 0, 0, 1, 1, 'h40);
    tick();
    applyStimulus(0, 0, 0, 1, 1, 'h41);
    tick();
    rst = 1'b1;
    applyStimulus(1, 2, 'h42, 1, 1, 'h43);
    @(negedge clk);
    checkOutput("midrst_h_ready", h_ready, 0);
    checkOutput("midrst_u_ready", u_ready, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_wr_en", wr_en, 0);
    checkOutput("midrst_wr_data", wr_data, 0);
    checkOutput("midrst_conflict", conflict_cnt, 0);
    checkOutput("midrst_h_wins", h_ready, 1);
    checkOutput("midrst_u_waits", u_ready, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Saturation of the conflict counter under continuous contention
    applyReset();
    applyStimulus(1, 0, 'h01, 1, 1, 'h02);
    runRandom(300, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("sat_conflict", conflict_cnt, 255);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Randomized traffic with occasional resets
    applyReset();
    runRandom(3000, 1'b0, 1'b1);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checkCount, errCount);
    $finish;
  end

endmodule
